// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared types and constants for the slot round controller
//
// Contents:
//   CREDIT_W      width of credit store and bet (4)
//   SYM_BITS_DEF  default reel symbol width (3, eight symbols)
//   MODE_CNT      number of payout tables (3)
//   state_t       round sequencer states
//   M3_TAB/M2_TAB triple / pair multipliers indexed by mode_num
//   Optional feature macro: SLOT_JACKPOT_EN (used by slot_payout and slot_round_ctrl)
package slot_pkg;

   localparam int CREDIT_W     = 4;
   localparam int SYM_BITS_DEF = 3;
   localparam int MODE_CNT     = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SPIN   = 3'd1,
      ST_STOP   = 3'd2,
      ST_EVAL   = 3'd3,
      ST_PAYOUT = 3'd4
   } state_t;

   // Element 0 belongs to mode 0.
   localparam logic [2:0] M3_TAB [MODE_CNT] = '{3'd4, 3'd6, 3'd3};
   localparam logic [2:0] M2_TAB [MODE_CNT] = '{3'd1, 3'd0, 3'd2};

endpackage

// File: rtl/slot_payout.sv
// rtl/slot_payout.sv - combinational payout evaluation of three captured reel symbols
//
// Ports:
//   bet       in   CREDIT_W  bet of the round
//   mode_num  in   2         payout table 0..2
//   sym0..2   in   SYM_BITS  captured reel symbols
//   payout    out  5         bet x multiplier, truncated to 5 bits
//   jackpot   out  1         all three symbols are the top symbol (only with SLOT_JACKPOT_EN)
module slot_payout
   import slot_pkg::*;
#(
   parameter int SYM_BITS = SYM_BITS_DEF
) (
   input  logic [CREDIT_W-1:0] bet,
   input  logic [1:0]          mode_num,
   input  logic [SYM_BITS-1:0] sym0,
   input  logic [SYM_BITS-1:0] sym1,
   input  logic [SYM_BITS-1:0] sym2,
   output logic [4:0]          payout
`ifdef SLOT_JACKPOT_EN
   ,
   output logic                jackpot
`endif
);

   logic       all3;
   logic       any2;
   logic [2:0] mult;

   always_comb begin
      all3 = (sym0 == sym1) && (sym1 == sym2);
      any2 = (sym0 == sym1) || (sym1 == sym2) || (sym0 == sym2);
      mult = 3'd0;
      if (all3)
         mult = M3_TAB[mode_num];
      else if (any2)
         mult = M2_TAB[mode_num];
      // 5-bit operands keep the product in 5 bits; overflow bits are dropped.
      payout = {1'b0, bet} * {2'b00, mult};
   end

`ifdef SLOT_JACKPOT_EN
   assign jackpot = all3 && (sym0 == {SYM_BITS{1'b1}});
`endif

endmodule

// File: rtl/slot_round_ctrl.sv
// rtl/slot_round_ctrl.sv - slot machine round sequencer: buttons, credit/bet, reel stop, payout
//
// Ports:
//   clk       in   1           rising-edge clock
//   rst       in   1           asynchronous active-low reset
//   start     in   1           level, rising edge requests a spin
//   bet_up    in   1           level, rising edge increments the bet
//   bet_dn    in   1           level, rising edge decrements the bet
//   mode      in   1           level, rising edge advances the payout table
//   reel_sym  in   3*SYM_BITS  live reel symbols, reel i at [i*SYM_BITS +: SYM_BITS]
//   reel_run  out  3           per-reel run enable
//   bet       out  4           current bet
//   sto       out  4           credit store
//   mode_num  out  2           payout table 0..2
//   won       out  1           last round paid something, held until next accepted start
//   busy      out  1           round in progress
//   reject    out  1           one-cycle pulse, start refused
//   Optional feature macro: SLOT_JACKPOT_EN (top-symbol triple fills the store)
module slot_round_ctrl
   import slot_pkg::*;
#(
   parameter int SYM_BITS    = SYM_BITS_DEF,
   parameter int SPIN_CYC    = 16,
   parameter int STAGGER     = 8,
   parameter int INIT_CREDIT = 10,
   parameter int BET_MAX     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  bet_up,
   input  logic                  bet_dn,
   input  logic                  mode,
   input  logic [3*SYM_BITS-1:0] reel_sym,
   output logic [2:0]            reel_run,
   output logic [CREDIT_W-1:0]   bet,
   output logic [CREDIT_W-1:0]   sto,
   output logic [1:0]            mode_num,
   output logic                  won,
   output logic                  busy,
   output logic                  reject
);

   localparam int CNT_MAX = (SPIN_CYC > STAGGER) ? SPIN_CYC : STAGGER;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0]    SPIN_LAST = CNT_W'(SPIN_CYC - 1);
   localparam logic [CNT_W-1:0]    STAG_LAST = CNT_W'(STAGGER - 1);
   localparam logic [CREDIT_W-1:0] BET_CAP   = CREDIT_W'(BET_MAX);
   localparam logic [CREDIT_W-1:0] STO_INIT  = CREDIT_W'(INIT_CREDIT);
   localparam logic [CREDIT_W-1:0] STO_FULL  = {CREDIT_W{1'b1}};

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [SYM_BITS-1:0] cap0, cap1, cap2;
   logic [4:0]          payout_c;
   logic [4:0]          payout_q;
   logic                start_q, up_q, dn_q, mode_q;
   logic                start_e, up_e, dn_e, mode_e;
   logic [CREDIT_W-1:0] bet_lim;
   logic [5:0]          sum;
   logic [CREDIT_W-1:0] new_sto;
   logic                won_next;
`ifdef SLOT_JACKPOT_EN
   logic                jackpot_c;
   logic                jackpot_q;
`endif

   slot_payout #(
      .SYM_BITS (SYM_BITS)
   ) u_payout (
      .bet      (bet),
      .mode_num (mode_num),
      .sym0     (cap0),
      .sym1     (cap1),
      .sym2     (cap2),
      .payout   (payout_c)
`ifdef SLOT_JACKPOT_EN
      ,
      .jackpot  (jackpot_c)
`endif
   );

   assign start_e = start  & ~start_q;
   assign up_e    = bet_up & ~up_q;
   assign dn_e    = bet_dn & ~dn_q;
   assign mode_e  = mode   & ~mode_q;
   assign busy    = (state != ST_IDLE);

   always_comb begin
      // The bet may never exceed what the store could cover.
      bet_lim  = (BET_CAP < sto) ? BET_CAP : sto;
      sum      = {2'b00, sto} + {1'b0, payout_q};
      new_sto  = (sum > 6'd15) ? STO_FULL : sum[CREDIT_W-1:0];
      won_next = (payout_q != 5'd0);
`ifdef SLOT_JACKPOT_EN
      if (jackpot_q) begin
         new_sto  = STO_FULL;
         won_next = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         reel_run <= 3'b000;
         bet      <= CREDIT_W'(1);
         sto      <= STO_INIT;
         mode_num <= 2'd0;
         won      <= 1'b0;
         reject   <= 1'b0;
         cap0     <= '0;
         cap1     <= '0;
         cap2     <= '0;
         payout_q <= 5'd0;
         start_q  <= 1'b0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         mode_q   <= 1'b0;
`ifdef SLOT_JACKPOT_EN
         jackpot_q <= 1'b0;
`endif
      end else begin
         start_q <= start;
         up_q    <= bet_up;
         dn_q    <= bet_dn;
         mode_q  <= mode;
         reject  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start_e) begin
                  // Start wins over any coincident bet/mode edge.
                  if ((bet != '0) && (bet <= sto)) begin
                     sto      <= sto - bet;
                     won      <= 1'b0;
                     reel_run <= 3'b111;
                     cnt      <= '0;
                     state    <= ST_SPIN;
                  end else begin
                     reject <= 1'b1;
                  end
               end else begin
                  if (up_e && !dn_e && (bet < bet_lim))
                     bet <= bet + CREDIT_W'(1);
                  else if (dn_e && !up_e && (bet > CREDIT_W'(1)))
                     bet <= bet - CREDIT_W'(1);
                  if (mode_e)
                     mode_num <= (mode_num == 2'd2) ? 2'd0 : mode_num + 2'd1;
               end
            end

            ST_SPIN: begin
               if (cnt == SPIN_LAST) begin
                  reel_run[0] <= 1'b0;
                  cap0        <= reel_sym[0 +: SYM_BITS];
                  cnt         <= '0;
                  state       <= ST_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_STOP: begin
               // reel_run[1] still high means reel 1 is the next to stop.
               if (cnt == STAG_LAST) begin
                  cnt <= '0;
                  if (reel_run[1]) begin
                     reel_run[1] <= 1'b0;
                     cap1        <= reel_sym[SYM_BITS +: SYM_BITS];
                  end else begin
                     reel_run[2] <= 1'b0;
                     cap2        <= reel_sym[2*SYM_BITS +: SYM_BITS];
                     state       <= ST_EVAL;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_EVAL: begin
               payout_q <= payout_c;
`ifdef SLOT_JACKPOT_EN
               jackpot_q <= jackpot_c;
`endif
               state <= ST_PAYOUT;
            end

            ST_PAYOUT: begin
               sto <= new_sto;
               won <= won_next;
               if ((bet > new_sto) && (new_sto != '0))
                  bet <= new_sto;
               state <= ST_IDLE;
            end

            default: begin
               reel_run <= 3'b000;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slot_round_ctrl.sv
// tb/tb_slot_round_ctrl.sv - scoreboard bench for slot_round_ctrl
module tb_slot_round_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       bet_up = 1'b0;
   logic       bet_dn = 1'b0;
   logic       mode = 1'b0;
   logic [8:0] reel_sym = 9'd0;
   logic [2:0] reel_run;
   logic [3:0] bet;
   logic [3:0] sto;
   logic [1:0] mode_num;
   logic       won;
   logic       busy;
   logic       reject;

   slot_round_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bet_up   (bet_up),
      .bet_dn   (bet_dn),
      .mode     (mode),
      .reel_sym (reel_sym),
      .reel_run (reel_run),
      .bet      (bet),
      .sto      (sto),
      .mode_num (mode_num),
      .won      (won),
      .busy     (busy),
      .reject   (reject)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int fall_cyc [3];
   int done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_reject;
      logic [3:0] sto;
      logic       won;
      logic [3:0] bet;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Monitor: a round completes when busy falls; a refused start shows as reject.
   initial begin
      exp_t       e;
      logic [2:0] prev_rr;
      logic       prev_busy;
      prev_rr   = 3'b000;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_rr   = 3'b000;
            prev_busy = 1'b0;
         end else begin
            for (int i = 0; i < 3; i++)
               if (prev_rr[i] && !reel_run[i]) fall_cyc[i] = cyc;
            if (prev_busy && !busy) done_cyc = cyc;
            if ((prev_busy && !busy) || reject) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_unexpected reject=%0d busy=%0d sto=%0d", reject, busy, sto);
               end else begin
                  e = sb.pop_front();
                  chk("sb_kind", {31'd0, reject}, {31'd0, e.is_reject});
                  chk("sb_sto", {28'd0, sto}, {28'd0, e.sto});
                  chk("sb_bet", {28'd0, bet}, {28'd0, e.bet});
                  if (!e.is_reject) chk("sb_won", {31'd0, won}, {31'd0, e.won});
               end
            end
            prev_rr   = reel_run;
            prev_busy = busy;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] syms(input int r0, input int r1, input int r2);
      return {3'(r2), 3'(r1), 3'(r0)};
   endfunction

   // which: 0 start, 1 bet_up, 2 bet_dn, 3 mode, 4 bet_up+bet_dn
   task automatic press(input int which, output int k);
      @(negedge clk);
      case (which)
         0: start = 1'b1;
         1: bet_up = 1'b1;
         2: bet_dn = 1'b1;
         3: mode = 1'b1;
         default: begin
            bet_up = 1'b1;
            bet_dn = 1'b1;
         end
      endcase
      @(negedge clk);
      start  = 1'b0;
      bet_up = 1'b0;
      bet_dn = 1'b0;
      mode   = 1'b0;
      k = cyc;
   endtask

   task automatic begin_round(input string name, input logic [8:0] sym, input logic [3:0] ded,
                              input logic [3:0] e_sto, input logic e_won, input logic [3:0] e_bet,
                              output int k);
      exp_t e;
      reel_sym    = sym;
      e.is_reject = 1'b0;
      e.sto       = e_sto;
      e.won       = e_won;
      e.bet       = e_bet;
      sb.push_back(e);
      press(0, k);
      chk({name, "_deduct"}, {28'd0, sto}, {28'd0, ded});
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
   endtask

   task automatic round(input string name, input logic [8:0] sym, input logic [3:0] ded,
                        input logic [3:0] e_sto, input logic e_won, input logic [3:0] e_bet);
      int k;
      begin_round(name, sym, ded, e_sto, e_won, e_bet, k);
      wait_idle(name);
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_run"}, {29'd0, reel_run}, 32'd0);
      chk({name, "_bet"}, {28'd0, bet}, 32'd1);
      chk({name, "_sto"}, {28'd0, sto}, 32'd10);
      chk({name, "_mode"}, {30'd0, mode_num}, 32'd0);
      chk({name, "_won"}, {31'd0, won}, 32'd0);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_reject"}, {31'd0, reject}, 32'd0);
   endtask

   initial begin
      int   k;
      int   d;
      exp_t e;

      repeat (3) @(negedge clk);
      chk_reset("rst0");
      rst = 1'b1;

      // Default round: triple 3, mode 0, bet 1 -> 9 + 4.
      begin_round("r1", syms(3, 3, 3), 4'd9, 4'd13, 1'b1, 4'd1, k);
      chk("r1_run", {29'd0, reel_run}, 32'd7);
      wait_idle("r1");
      chk("r1_fall0", fall_cyc[0], k + 16);
      chk("r1_fall1", fall_cyc[1], k + 24);
      chk("r1_fall2", fall_cyc[2], k + 32);
      chk("r1_end", done_cyc, k + 34);

      press(3, d); chk("mode_1", {30'd0, mode_num}, 32'd1);
      press(1, d); chk("bet_up_2", {28'd0, bet}, 32'd2);
      press(4, d); chk("bet_both", {28'd0, bet}, 32'd2);
      press(1, d); chk("bet_up_3", {28'd0, bet}, 32'd3);
      press(1, d); chk("bet_cap", {28'd0, bet}, 32'd3);

      // Pair in mode 1 pays nothing.
      round("r2", syms(1, 1, 5), 4'd10, 4'd10, 1'b0, 4'd3);

      // Triple in mode 1 at bet 3: 7 + 18 saturates; buttons ignored mid-spin.
      begin_round("r3", syms(4, 4, 4), 4'd7, 4'd15, 1'b1, 4'd3, k);
      repeat (4) @(negedge clk);
      press(0, d); chk("spin_start_run", {29'd0, reel_run}, 32'd7);
      press(1, d); chk("spin_bet", {28'd0, bet}, 32'd3);
      press(3, d); chk("spin_mode", {30'd0, mode_num}, 32'd1);
      wait_idle("r3");

      round("r4", syms(0, 1, 2), 4'd12, 4'd12, 1'b0, 4'd3);
      round("r5", syms(0, 1, 2), 4'd9, 4'd9, 1'b0, 4'd3);

      press(3, d); chk("mode_2", {30'd0, mode_num}, 32'd2);
      // Reels 0 and 2 match in mode 2: 6 + 3*2.
      round("r6", syms(5, 6, 5), 4'd6, 4'd12, 1'b1, 4'd3);
      round("r7", syms(0, 1, 2), 4'd9, 4'd9, 1'b0, 4'd3);
      round("r8", syms(0, 1, 2), 4'd6, 4'd6, 1'b0, 4'd3);
      round("r9", syms(0, 1, 2), 4'd3, 4'd3, 1'b0, 4'd3);

      press(2, d); chk("bet_dn_2", {28'd0, bet}, 32'd2);
      // Store drops to 1 so the bet is clamped to 1.
      round("r10", syms(0, 1, 2), 4'd1, 4'd1, 1'b0, 4'd1);
      for (int i = 0; i < 20; i++) press(1, d);
      chk("bet_sat_sto", {28'd0, bet}, 32'd1);
      press(2, d); chk("bet_floor", {28'd0, bet}, 32'd1);

      // Store reaches 0; bet stays 1 and every start is refused.
      round("r11", syms(0, 1, 2), 4'd0, 4'd0, 1'b0, 4'd1);
      e.is_reject = 1'b1;
      e.sto       = 4'd0;
      e.won       = 1'b0;
      e.bet       = 4'd1;
      sb.push_back(e);
      press(0, d);
      chk("rej_busy", {31'd0, busy}, 32'd0);
      chk("rej_sto", {28'd0, sto}, 32'd0);
      @(negedge clk);
      chk("rej_width", {31'd0, reject}, 32'd0);

      press(3, d); chk("mode_wrap", {30'd0, mode_num}, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      #1 chk_reset("rst1");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Reset in the middle of the reel stop sequence.
      press(3, d);
      press(1, d);
      chk("pre_bet", {28'd0, bet}, 32'd2);
      reel_sym = syms(2, 2, 2);
      press(0, k);
      chk("mid_deduct", {28'd0, sto}, 32'd8);
      repeat (20) @(negedge clk);
      chk("mid_run", {29'd0, reel_run}, 32'd6);
      #2 rst = 1'b0;
      #1 chk_reset("rst_mid");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

`ifdef SLOT_JACKPOT_EN
      round("r12", syms(7, 7, 7), 4'd9, 4'd15, 1'b1, 4'd1);
`else
      round("r12", syms(7, 7, 7), 4'd9, 4'd13, 1'b1, 4'd1);
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
